// File: rtl/sort_loader.sv
// sort_loader: packs four serial bytes into one a..d frame for a 4-input sorter.
// Optional macro LOADER_TIMEOUT_EN discards partial frames after TIMEOUT idle cycles.
module sort_loader #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             frame_valid,
  input  logic             frame_ack,
  output logic [1:0]       fill_cnt,
  output logic             drop
);

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [1:0]       fill_cnt_q, fill_cnt_d;
  logic [WIDTH-1:0] s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic             frame_valid_q, frame_valid_d;
  logic             accept;
  logic             timeout_fire;
  logic [1:0]       slot;

  assign din_ready   = (state_q == FILL) && !reset;
  assign accept      = din_valid && din_ready;
  assign a           = a_q;
  assign b           = b_q;
  assign c           = c_q;
  assign d           = d_q;
  assign frame_valid = frame_valid_q;
  assign fill_cnt    = fill_cnt_q;

`ifdef LOADER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              drop_q, drop_d;

  assign timeout_fire = (state_q == FILL) && (fill_cnt_q != 2'd0) &&
                        (idle_q == IDLE_W'(TIMEOUT));
  assign drop         = drop_q;

  always_comb begin
    idle_d = idle_q;
    drop_d = timeout_fire;
    if (state_q != FILL || fill_cnt_q == 2'd0 || accept || timeout_fire)
      idle_d = '0;
    else
      idle_d = idle_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_q <= '0;
      drop_q <= 1'b0;
    end else begin
      idle_q <= idle_d;
      drop_q <= drop_d;
    end
  end
`else
  assign timeout_fire = 1'b0;
  assign drop         = 1'b0;
`endif

  // A byte landing on the timeout edge starts a fresh frame at slot 0.
  assign slot = timeout_fire ? 2'd0 : fill_cnt_q;

  always_comb begin
    state_d       = state_q;
    fill_cnt_d    = fill_cnt_q;
    s0_d          = s0_q;
    s1_d          = s1_q;
    s2_d          = s2_q;
    a_d           = a_q;
    b_d           = b_q;
    c_d           = c_q;
    d_d           = d_q;
    frame_valid_d = frame_valid_q;

    case (state_q)
      FILL: begin
        if (timeout_fire)
          fill_cnt_d = 2'd0;
        if (accept) begin
          fill_cnt_d = slot + 2'd1;
          case (slot)
            2'd0: s0_d = din;
            2'd1: s1_d = din;
            2'd2: s2_d = din;
            default: begin
              // Last byte bypasses the shadow and lands straight in d.
              a_d           = s0_q;
              b_d           = s1_q;
              c_d           = s2_q;
              d_d           = din;
              frame_valid_d = 1'b1;
              fill_cnt_d    = 2'd0;
              state_d       = FULL;
            end
          endcase
        end
      end
      FULL: begin
        if (frame_ack) begin
          frame_valid_d = 1'b0;
          state_d       = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FILL;
      fill_cnt_q    <= 2'd0;
      s0_q          <= '0;
      s1_q          <= '0;
      s2_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      c_q           <= '0;
      d_q           <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fill_cnt_q    <= fill_cnt_d;
      s0_q          <= s0_d;
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      a_q           <= a_d;
      b_q           <= b_d;
      c_q           <= c_d;
      d_q           <= d_d;
      frame_valid_q <= frame_valid_d;
    end
  end

endmodule

// File: doc/sort_loader.md
SORT_LOADER -- requirements
Module: sort_loader

Interface
REQ-001 Parameter WIDTH, default 8: bit width of each input byte and each output lane.
REQ-002 Parameter TIMEOUT, default 16: idle-cycle limit for a partial frame (used only under LOADER_TIMEOUT_EN).
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port din, input, WIDTH: serial data byte.
REQ-006 Port din_valid, input, 1: din carries a byte this cycle.
REQ-007 Port din_ready, output, 1: loader can accept a byte this cycle.
REQ-008 Ports a, b, c, d, output, WIDTH each: frame lanes feeding the downstream sorter inputs a..d.
REQ-009 Port frame_valid, output, 1: a..d hold a complete, unconsumed frame.
REQ-010 Port frame_ack, input, 1: downstream has consumed the frame.
REQ-011 Port fill_cnt, output, 2: number of bytes held in the current partial frame.
REQ-012 Port drop, output, 1: one-cycle pulse when a partial frame is discarded.

Function
REQ-013 SHALL implement a two-state FSM: FILL and FULL.
REQ-014 SHALL drive din_ready = 1 in FILL and 0 in FULL, combinationally from the state; din_ready is 0 while reset is high.
REQ-015 SHALL accept a byte only on a cycle where din_valid && din_ready; it writes shadow slot fill_cnt (0->a, 1->b, 2->c, 3->d), then fill_cnt increments.
REQ-016 SHALL keep a..d unchanged while a frame is filling; shadow slots are not visible on the outputs.
REQ-017 On accepting the 4th byte (fill_cnt==3): next edge copies all four slots to a..d simultaneously (the 4th byte goes directly into d), sets frame_valid=1, sets fill_cnt=0, enters FULL; one-cycle latency from the last byte to frame_valid.
REQ-018 In FULL, frame_ack high on an edge SHALL clear frame_valid on that edge and return to FILL; a..d SHALL hold their values until the next frame completes.
REQ-019 frame_ack in FILL SHALL be ignored, with no state change.
REQ-020 din_valid in FULL SHALL be ignored; the byte is not accepted and the upstream holds it.
REQ-021 Back-to-back operation: the first byte of the next frame SHALL be accepted no earlier than the cycle after ack, giving a minimum of 5 cycles per frame with ack held high.
REQ-022 din values SHALL be stored unmodified, with no arithmetic; all lanes are WIDTH bits.

Reset
REQ-023 With reset high on an edge: state=FILL, fill_cnt=0, a=b=c=d=0, shadow slots=0, frame_valid=0, drop=0, idle counter=0.
REQ-024 Reset mid-frame or in FULL SHALL discard all content without a drop pulse.
REQ-025 Reset SHALL take priority over din_valid and frame_ack on the same edge.

Configuration
REQ-026 Macro LOADER_TIMEOUT_EN defined: in FILL with fill_cnt!=0, an idle counter increments on each cycle with no accepted byte and clears on each accepted byte.
REQ-027 With the macro defined, when the idle counter reaches TIMEOUT: fill_cnt=0, idle counter=0, drop=1 for exactly one cycle; a..d and frame_valid are unaffected.
REQ-028 With the macro defined, a byte accepted on the same edge the timeout fires SHALL count as slot 0 of a fresh frame.
REQ-029 Macro undefined: no idle counter is built, drop is tied to 0, and partial frames wait indefinitely.

Verification
REQ-030 Reset, then bytes 0x10,0x20,0x30,0x40 on 4 consecutive cycles -> one cycle later a=0x10, b=0x20, c=0x30, d=0x40, frame_valid=1, din_ready=0.
REQ-031 From REQ-030 state, din_valid=1 with din=0x55 held for 3 cycles, no ack -> a..d unchanged, fill_cnt=0; frame_ack pulse -> frame_valid=0, din_ready=1 next cycle, then 0x55 is accepted as slot 0.
REQ-032 Bytes 0xFF,0x00 with valid gaps of 2 cycles, then 0x7F,0x80 -> a..d stay 0 until the 4th byte; then a=0xFF, b=0x00, c=0x7F, d=0x80.
REQ-033 Reset asserted after 3 bytes of a frame -> all outputs 0, fill_cnt=0, drop=0; a new 4-byte frame completes normally.
REQ-034 LOADER_TIMEOUT_EN, TIMEOUT=16: 2 bytes, then 16 idle cycles -> drop=1 for one cycle, fill_cnt=0; then 4 bytes 1,2,3,4 -> a=1, b=2, c=3, d=4.
REQ-035 50 random 4-byte frames ({$random}%256), each acked 1 cycle after frame_valid -> each a..d matches its input sequence, and the downstream sorter outputs are checked against a reference sort.
